// File: rtl/instr_fetch.sv
`default_nettype none
// ============================================================================
//  Module   : instr_fetch
//  Purpose  : PC ownership, instruction memory addressing and IF/ID capture
//             with stall, flush, redirect, range check and sticky halt.
//  Revision : 1.0
// ============================================================================
module instr_fetch #(
    parameter int                ADDR_W    = 6,
    parameter int                DATA_W    = 32,
    parameter int                MEM_DEPTH = 52,
    parameter int                RESET_PC  = 0,
    parameter logic [DATA_W-1:0] HALT_WORD = 32'hFFFF_FFFF
) (
    input  logic              reloj,
    input  logic              reset,
    input  logic              stall,
    input  logic              flush,
    input  logic              branch_taken,
    input  logic [ADDR_W-1:0] branch_target,
    input  logic              jump,
    input  logic [ADDR_W-1:0] jump_target,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [DATA_W-1:0] imem_data,
    output logic [DATA_W-1:0] instr_out,
    output logic [ADDR_W-1:0] pc_out,
    output logic              instr_valid,
    output logic              halted,
    output logic              addr_err,
    output logic [15:0]       fetch_count
);

    localparam logic [ADDR_W:0]   c_depth    = (ADDR_W+1)'(MEM_DEPTH);
    localparam logic [ADDR_W-1:0] c_last     = ADDR_W'(MEM_DEPTH - 1);
    localparam logic [ADDR_W-1:0] c_reset_pc = ADDR_W'(RESET_PC);
    localparam logic [ADDR_W-1:0] c_one      = ADDR_W'(1);

    typedef enum logic [1:0] {
        S_BOOT = 2'd0,
        S_RUN  = 2'd1,
        S_HALT = 2'd2
    } state_t;

    state_t              r_state;
    logic [ADDR_W-1:0]   r_pc;
    logic [DATA_W-1:0]   r_instr;
    logic [ADDR_W-1:0]   r_pc_out;
    logic                r_valid;
    logic                r_halted;
    logic                r_addr_err;
    logic [15:0]         r_count;

    logic                w_redirect;
    logic [ADDR_W-1:0]   w_target;
    logic                w_target_bad;
    logic [ADDR_W-1:0]   w_seq_pc;

    // Jump outranks branch; the range check uses one extra bit so it still
    // works when MEM_DEPTH fills the whole address space.
    always_comb begin
        w_redirect   = jump | branch_taken;
        w_target     = jump ? jump_target : branch_target;
        w_target_bad = ({1'b0, w_target} >= c_depth);
        w_seq_pc     = (r_pc == c_last) ? '0 : (r_pc + c_one);
    end

    always_ff @(posedge reloj or negedge reset) begin
        if (!reset) begin
            r_state    <= S_BOOT;
            r_pc       <= c_reset_pc;
            r_instr    <= '0;
            r_pc_out   <= '0;
            r_valid    <= 1'b0;
            r_halted   <= 1'b0;
            r_addr_err <= 1'b0;
            r_count    <= '0;
        end else begin
            case (r_state)
                S_BOOT: begin
                    r_state <= S_RUN;
                end
                S_RUN: begin
                    if (w_redirect) begin
                        // Wrong-path slot is squashed even when stalled.
                        r_pc    <= w_target_bad ? '0 : w_target;
                        r_valid <= 1'b0;
                        r_instr <= '0;
                        if (w_target_bad) begin
                            r_addr_err <= 1'b1;
                        end
                    end else begin
                        if (!stall) begin
                            r_pc <= w_seq_pc;
                        end
                        if (flush) begin
                            r_valid <= 1'b0;
                            r_instr <= '0;
                        end else if (!stall) begin
                            r_instr  <= imem_data;
                            r_pc_out <= r_pc;
                            r_valid  <= 1'b1;
                            r_count  <= r_count + 16'd1;
                            if (imem_data == HALT_WORD) begin
                                r_halted <= 1'b1;
                                r_state  <= S_HALT;
                            end
                        end
                    end
                end
                S_HALT: begin
                    r_valid <= 1'b0;
                end
                default: begin
                    r_state <= S_BOOT;
                end
            endcase
        end
    end

    assign imem_addr   = r_pc;
    assign instr_out   = r_instr;
    assign pc_out      = r_pc_out;
    assign instr_valid = r_valid;
    assign halted      = r_halted;
    assign addr_err    = r_addr_err;
    assign fetch_count = r_count;

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch.sv
`default_nettype none
// ============================================================================
//  Module   : tb_instr_fetch
//  Purpose  : Scoreboard bench for instr_fetch against a per-edge reference
//             model of the fetch rules.
//  Revision : 1.0
// ============================================================================
module tb_instr_fetch;

    localparam int          c_depth = 52;
    localparam logic [31:0] c_halt  = 32'hFFFF_FFFF;

    logic        reloj = 1'b0;
    logic        reset;
    logic        stall, flush, branch_taken, jump;
    logic [5:0]  branch_target, jump_target, imem_addr, pc_out;
    logic [31:0] imem_data, instr_out;
    logic        instr_valid, halted, addr_err;
    logic [15:0] fetch_count;

    logic [31:0] mem [0:63];
    assign imem_data = mem[imem_addr];

    instr_fetch dut (
        .reloj         (reloj),
        .reset         (reset),
        .stall         (stall),
        .flush         (flush),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .jump          (jump),
        .jump_target   (jump_target),
        .imem_addr     (imem_addr),
        .imem_data     (imem_data),
        .instr_out     (instr_out),
        .pc_out        (pc_out),
        .instr_valid   (instr_valid),
        .halted        (halted),
        .addr_err      (addr_err),
        .fetch_count   (fetch_count)
    );

    always #5 reloj = ~reloj;

    int unsigned ecnt = 0;
    always @(posedge reloj) ecnt <= ecnt + 1;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: architectural view of the fetch stage after each edge.
    typedef struct {
        int unsigned edge_no;
        int          addr;
        logic        valid;
        logic [31:0] instr;
        int          pcout;
        int          cnt;
        logic        hlt;
        logic        err;
    } exp_t;

    exp_t q[$];

    int          m_pc, m_pcout, m_count;
    logic        m_run, m_halted, m_err, m_valid;
    logic [31:0] m_instr;

    task automatic m_reset();
        m_pc = 0; m_pcout = 0; m_count = 0;
        m_run = 1'b0; m_halted = 1'b0; m_err = 1'b0; m_valid = 1'b0;
        m_instr = '0;
    endtask

    task automatic m_step(input logic s, input logic f, input logic b, input int bt,
                          input logic j, input int jt);
        int tgt;
        if (!m_run) begin
            m_run = 1'b1;
        end else if (m_halted) begin
            m_valid = 1'b0;
        end else if (j || b) begin
            tgt = j ? jt : bt;
            if (tgt >= c_depth) begin
                m_pc  = 0;
                m_err = 1'b1;
            end else begin
                m_pc = tgt;
            end
            m_valid = 1'b0;
            m_instr = '0;
        end else if (f) begin
            m_valid = 1'b0;
            m_instr = '0;
            if (!s) m_pc = (m_pc + 1) % c_depth;
        end else if (!s) begin
            m_instr = mem[m_pc];
            m_pcout = m_pc;
            m_valid = 1'b1;
            m_count = (m_count + 1) % 65536;
            if (m_instr == c_halt) m_halted = 1'b1;
            m_pc = (m_pc + 1) % c_depth;
        end
        q.push_back('{edge_no: ecnt + 1, addr: m_pc, valid: m_valid, instr: m_instr,
                      pcout: m_pcout, cnt: m_count, hlt: m_halted, err: m_err});
    endtask

    // Monitor: pops the expectation for each edge the DUT has just taken.
    exp_t e;
    always @(negedge reloj) begin
        if (reset === 1'b1 && q.size() > 0 && q[0].edge_no <= ecnt) begin
            e = q.pop_front();
            chk("edge_seq", ecnt, e.edge_no);
            chk("imem_addr", imem_addr, e.addr);
            chk("instr_valid", instr_valid, e.valid);
            chk("instr_out", instr_out, e.instr);
            if (e.valid) chk("pc_out", pc_out, e.pcout);
            chk("fetch_count", fetch_count, e.cnt);
            chk("halted", halted, e.hlt);
            chk("addr_err", addr_err, e.err);
        end
    end

    task automatic cyc(input logic s, input logic f, input logic b, input int bt,
                       input logic j, input int jt);
        stall = s; flush = f; branch_taken = b; jump = j;
        branch_target = 6'(bt); jump_target = 6'(jt);
        m_step(s, f, b, bt, j, jt);
        @(posedge reloj);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, 0, 1'b0, 0);
    endtask

    task automatic chk_reset_vals();
        chk("rst_imem_addr", imem_addr, 0);
        chk("rst_instr_out", instr_out, 0);
        chk("rst_pc_out", pc_out, 0);
        chk("rst_valid", instr_valid, 0);
        chk("rst_halted", halted, 0);
        chk("rst_addr_err", addr_err, 0);
        chk("rst_count", fetch_count, 0);
    endtask

    // Called at posedge+1; waits past the negedge so no expectation is lost.
    task automatic assert_reset_mid();
        #6;
        reset = 1'b0;
        #1;
        chk_reset_vals();
        q.delete();
        m_reset();
        repeat (2) @(posedge reloj);
        #1;
        stall = 1'b0; flush = 1'b0; branch_taken = 1'b0; jump = 1'b0;
        reset = 1'b1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = i;
        reset = 1'b0; stall = 1'b0; flush = 1'b0; branch_taken = 1'b0; jump = 1'b0;
        branch_target = '0; jump_target = '0;
        m_reset();
        repeat (3) @(posedge reloj);
        #1;
        chk_reset_vals();
        reset = 1'b1;

        // Sequential fetch with a 3-cycle stall at PC=5, then wrap.
        idle(1);
        chk("boot_bubble", instr_valid, 0);
        idle(5);
        chk("pre_stall_addr", imem_addr, 5);
        repeat (3) cyc(1'b1, 1'b0, 1'b0, 0, 1'b0, 0);
        chk("stall_addr", imem_addr, 5);
        chk("stall_instr", instr_out, 4);
        chk("stall_count", fetch_count, 5);
        idle(1);
        chk("resume_instr", instr_out, 5);
        idle(47);
        chk("count_53", fetch_count, 53);
        chk("wrap_instr", instr_out, 0);
        chk("wrap_pc_out", pc_out, 0);
        chk("wrap_addr", imem_addr, 1);

        // Jump beats branch and stall.
        cyc(1'b1, 1'b0, 1'b1, 9, 1'b1, 20);
        chk("jump_addr", imem_addr, 20);
        chk("jump_bubble", instr_valid, 0);
        idle(1);
        chk("jump_instr", instr_out, 20);
        chk("jump_valid", instr_valid, 1);

        // Out-of-range branch, then sticky error through valid redirects.
        cyc(1'b0, 1'b0, 1'b1, 60, 1'b0, 0);
        chk("bad_tgt_addr", imem_addr, 0);
        chk("bad_tgt_err", addr_err, 1);
        cyc(1'b0, 1'b0, 1'b1, 10, 1'b0, 0);
        cyc(1'b0, 1'b0, 1'b0, 0, 1'b1, 3);
        idle(2);
        chk("err_sticky", addr_err, 1);
        chk("after_jump3_addr", imem_addr, 5);

        // Randomized control traffic.
        for (int i = 0; i < 300; i++) begin
            cyc(($urandom % 4) == 0, ($urandom % 8) == 0, ($urandom % 8) == 0,
                int'($urandom_range(0, 63)), ($urandom % 10) == 0,
                int'($urandom_range(0, 63)));
        end

        // Asynchronous reset mid-run with stall held.
        stall = 1'b1;
        assert_reset_mid();
        idle(1);
        chk("rst_boot_valid", instr_valid, 0);
        chk("rst_boot_addr", imem_addr, 0);
        idle(1);
        chk("rst_first_instr", instr_out, 0);
        chk("rst_first_valid", instr_valid, 1);
        chk("rst_first_count", fetch_count, 1);

        // Halt word at address 7.
        mem[7] = c_halt;
        assert_reset_mid();
        idle(9);
        chk("halt_flag", halted, 1);
        chk("halt_valid", instr_valid, 1);
        chk("halt_instr", instr_out, c_halt);
        chk("halt_addr", imem_addr, 8);
        cyc(1'b1, 1'b1, 1'b1, 60, 1'b0, 0);
        chk("halt_valid_drop", instr_valid, 0);
        chk("halt_err_ignored", addr_err, 0);
        for (int i = 0; i < 10; i++) begin
            cyc($urandom % 2 == 0, 1'b1, $urandom % 2 == 0,
                int'($urandom_range(0, 51)), 1'b1, int'($urandom_range(0, 51)));
        end
        chk("halt_addr_frozen", imem_addr, 8);
        chk("halt_count_frozen", fetch_count, 8);
        chk("halt_instr_kept", instr_out, c_halt);

        @(negedge reloj);
        #1;
        chk("queue_drained", q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/instr_fetch.md
# instr_fetch

Instruction fetch stage of the single-cycle-memory datapath. Owns the program counter, drives the 6-bit word address into the asynchronous-read instruction memory and captures the returned 32-bit word into the IF/ID pipeline register. Handles stall, flush, branch/jump redirect, out-of-range target detection and a sticky halt on the halt opcode.

## Interface
Parameters:
- ADDR_W, 6, PC/word-address width
- DATA_W, 32, instruction width
- MEM_DEPTH, 52, number of valid instruction words (addresses 0..MEM_DEPTH-1)
- RESET_PC, 0, PC value after reset
- HALT_WORD, 32'hFFFF_FFFF, instruction encoding that halts fetch

Ports:
- reloj  in  1  clock, rising edge
- reset  in  1  reset, asynchronous, active-low
- stall  in  1  hold PC and IF/ID register
- flush  in  1  invalidate IF/ID register next edge
- branch_taken  in  1  redirect to branch_target
- branch_target  in  ADDR_W  branch destination word address
- jump  in  1  redirect to jump_target (beats branch_taken)
- jump_target  in  ADDR_W  jump destination word address
- imem_addr  out  ADDR_W  address to instruction memory (= PC)
- imem_data  in  DATA_W  combinational read data from instruction memory
- instr_out  out  DATA_W  IF/ID instruction
- pc_out  out  ADDR_W  IF/ID: address instr_out was fetched from
- instr_valid  out  1  IF/ID holds a real instruction
- halted  out  1  fetch stopped on HALT_WORD
- addr_err  out  1  sticky: a redirect target was >= MEM_DEPTH
- fetch_count  out  16  instructions delivered to IF/ID (wraps at 2^16)

## Operation
- States: BOOT, RUN, HALT. Reset -> BOOT. BOOT -> RUN unconditionally after one edge (memory address settles; IF/ID stays invalid). RUN -> HALT when an instruction equal to HALT_WORD is captured into IF/ID. HALT is left only by reset.
- imem_addr is driven combinationally from the PC register; no other logic between them.
- Next-PC priority in RUN (highest first): jump -> jump_target; branch_taken -> branch_target; stall -> PC unchanged; else PC+1.
- Sequential wrap: PC == MEM_DEPTH-1 with no redirect -> next PC = 0 (no error).
- Redirect target >= MEM_DEPTH: PC loads 0 instead, addr_err set (sticky until reset).
- IF/ID update in RUN (priority): redirect or flush -> instr_valid=0, instr_out=0; stall -> hold; else instr_out=imem_data, pc_out=PC, instr_valid=1, fetch_count+1.
- Redirect overrides stall (wrong-path slot squashed, PC moves). Flush with stall: IF/ID cleared, PC held.
- HALT: PC frozen; IF/ID keeps the halt word; instr_valid drops to 0 on the edge after entry; all of stall/flush/branch_taken/jump ignored; fetch_count frozen.
- BOOT: all control inputs ignored.

## Timing
- Reset values (asynchronous, on reset low): PC=RESET_PC, imem_addr=RESET_PC, instr_out=0, pc_out=0, instr_valid=0, halted=0, addr_err=0, fetch_count=0, state=BOOT.
- Reset asserted mid-operation clears everything immediately, independent of reloj; in-flight redirect is lost.
- Fetch latency: word at address A appears on instr_out with instr_valid=1 one edge after PC=A (edge 2 after reset release for RESET_PC).
- Redirect asserted in cycle N: PC=target after edge N; target instruction valid after edge N+1; exactly one bubble.
- halted rises on the same edge the halt word is captured (instr_valid=1 for that one cycle with instr_out=HALT_WORD); instr_valid=0 from the next edge.
- fetch_count increments on the same edge instr_valid is written 1.

## Test plan
- Memory loaded 0..51 = address value; release reset, no stalls -> instr_out 0,1,2,… from edge 2, pc_out matches, word 51 followed by word 0, fetch_count=53 after 53 deliveries.
- stall high 3 cycles at PC=5 -> imem_addr stays 5, instr_out holds word 4, fetch_count unchanged, resume delivers 5 next.
- jump=1,jump_target=20 together with branch_taken=1,branch_target=9, stall=1 -> PC=20, one cycle instr_valid=0, then instr_out=word 20.
- branch_taken with branch_target=60 -> PC=0, addr_err=1 and stays 1 through later valid redirects.
- HALT_WORD at address 7 -> halted=1 at capture, instr_valid=0 next cycle, jump/flush ignored for 10 cycles, imem_addr stays 8.
- reset pulled low mid-run while stall=1 -> all outputs at reset values within the same cycle; after release, BOOT bubble then word RESET_PC.
